// File: rtl/apb_spi_bridge.sv
// -----------------------------------------------------------------------------
// apb_spi_bridge
// APB3 slave that turns register accesses into one-cycle read/write strobes
// for an SPI master core. Writes to address 0x1 can optionally be buffered in
// a 4-deep TX FIFO that a small drain FSM feeds to the SPI master whenever it
// is idle.
//
// Optional feature macro: APB_SPI_BRIDGE_TXFIFO_EN
//   defined   : 0x1 writes go through the TX FIFO, 0x8 reads the FIFO level
//   undefined : 0x1 writes strobe o_WR1 directly, 0x8 is an error address
//
// Ports
//   PCLK, PRESETn          clock (rising edge) / async active-low reset
//   PSEL, PENABLE, PWRITE  APB3 control
//   PADDR[3:0]             register address
//   PWDATA[7:0]            APB write data
//   PRDATA[7:0]            APB read data
//   PREADY, PSLVERR        APB completion / error
//   o_WR0..o_WR3           write strobes to SPI master (CONFIG, TX, RX, CMD)
//   o_DR0..o_DR3           read strobes to SPI master (STATE, RX, OPT2, OPT3)
//   o_PWDATA[7:0]          data accompanying an o_WRn strobe (0 otherwise)
//   i_PRDATA[7:0]          SPI master read data, valid the cycle after o_DRn
//   i_BUSY                 SPI master transfer in progress
//
// Drain FSM
//   state     | meaning
//   D_IDLE    | waiting for a queued byte and an idle SPI master
//   D_WAITHI  | byte handed over, waiting for i_BUSY to rise (16-cycle timeout)
//   D_WAITLO  | SPI master busy, waiting for i_BUSY to fall
// -----------------------------------------------------------------------------
module apb_spi_bridge (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [3:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR,
   output logic       o_WR0,
   output logic       o_WR1,
   output logic       o_WR2,
   output logic       o_WR3,
   output logic       o_DR0,
   output logic       o_DR1,
   output logic       o_DR2,
   output logic       o_DR3,
   output logic [7:0] o_PWDATA,
   input  logic [7:0] i_PRDATA,
   input  logic       i_BUSY
);

   // run is low while in reset so every combinational output is forced to its
   // reset value even if the bus is not idle.
   logic       run;
   logic       access;
   logic       rd_pend;
   logic [7:0] prdata_q;

   logic       wr_imm, wr_fifo, rd_spi, rd_stat, dec_err;
   logic       cpu_wr, cpu_rd;
   logic [3:0] wr_sel, rd_sel;

   logic       push, pop;
   logic [2:0] level;
   logic [7:0] head;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) run <= 1'b0;
      else          run <= 1'b1;
   end

   assign access = PSEL & PENABLE & run;

   always_comb begin
      wr_imm  = 1'b0;
      wr_fifo = 1'b0;
      rd_spi  = 1'b0;
      rd_stat = 1'b0;
      dec_err = 1'b0;
      if (PWRITE) begin
         if (PADDR[3:2] == 2'b00) begin
`ifdef APB_SPI_BRIDGE_TXFIFO_EN
            if (PADDR[1:0] == 2'd1) wr_fifo = 1'b1;
            else                    wr_imm  = 1'b1;
`else
            wr_imm = 1'b1;
`endif
         end else begin
            dec_err = 1'b1;
         end
      end else begin
         if (PADDR[3:2] == 2'b01)
            rd_spi = 1'b1;
`ifdef APB_SPI_BRIDGE_TXFIFO_EN
         else if (PADDR == 4'h8)
            rd_stat = 1'b1;
`endif
         else
            dec_err = 1'b1;
      end
   end

   // Read strobe only in the first access cycle; rd_pend marks the wait state
   // in which the SPI master's data is returned.
   assign cpu_wr = access & wr_imm;
   assign cpu_rd = access & rd_spi & ~rd_pend;
   assign wr_sel = cpu_wr ? (4'b0001 << PADDR[1:0]) : 4'b0000;
   assign rd_sel = cpu_rd ? (4'b0001 << PADDR[1:0]) : 4'b0000;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rd_pend  <= 1'b0;
         prdata_q <= 8'h00;
      end else begin
         rd_pend <= cpu_rd;
         if (access & rd_pend)
            prdata_q <= i_PRDATA;
         else if (access & rd_stat)
            prdata_q <= {5'b00000, level};
      end
   end

   // Returned data is passed through in its completion cycle and then held.
   always_comb begin
      PRDATA = prdata_q;
      if (access & rd_pend)
         PRDATA = i_PRDATA;
      else if (access & rd_stat)
         PRDATA = {5'b00000, level};
   end

   assign PREADY  = access & (dec_err | wr_imm | push | rd_stat | rd_pend);
   assign PSLVERR = access & dec_err;

   assign o_WR0 = wr_sel[0];
   assign o_WR1 = wr_sel[1] | pop;
   assign o_WR2 = wr_sel[2];
   assign o_WR3 = wr_sel[3];
   assign o_DR0 = rd_sel[0];
   assign o_DR1 = rd_sel[1];
   assign o_DR2 = rd_sel[2];
   assign o_DR3 = rd_sel[3];

   assign o_PWDATA = cpu_wr ? PWDATA : (pop ? head : 8'h00);

`ifdef APB_SPI_BRIDGE_TXFIFO_EN
   typedef enum logic [1:0] {
      D_IDLE   = 2'd0,
      D_WAITHI = 2'd1,
      D_WAITLO = 2'd2
   } d_state_t;

   d_state_t   d_state, d_next;
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] level_q;
   logic [3:0] tmo;
   logic       full, empty, cpu_strobe;

   assign full       = (level_q == 3'd4);
   assign empty      = (level_q == 3'd0);
   assign level      = level_q;
   assign head       = fifo_mem[rd_ptr];
   assign cpu_strobe = cpu_wr | cpu_rd;

   // A stalled push completes in the same cycle the drain frees a slot.
   assign push = access & wr_fifo & (~full | pop);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) d_state <= D_IDLE;
      else          d_state <= d_next;
   end

   always_comb begin
      d_next = d_state;
      case (d_state)
         D_IDLE:   if (pop) d_next = D_WAITHI;
         D_WAITHI: begin
            if (i_BUSY)           d_next = D_WAITLO;
            else if (tmo == 4'd0) d_next = D_IDLE;
         end
         D_WAITLO: if (!i_BUSY) d_next = D_IDLE;
         default:  d_next = D_IDLE;
      endcase
   end

   always_comb begin
      pop = (d_state == D_IDLE) & ~empty & ~i_BUSY & ~cpu_strobe;
   end

   // Loaded with 15 on hand-over: WAITHI lasts 16 cycles without i_BUSY.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         tmo <= 4'd0;
      else if (pop)
         tmo <= 4'd15;
      else if ((d_state == D_WAITHI) && !i_BUSY && (tmo != 4'd0))
         tmo <= tmo - 4'd1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr  <= 2'd0;
         rd_ptr  <= 2'd0;
         level_q <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 3'd1;
            2'b01:   level_q <= level_q - 3'd1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (push) fifo_mem[wr_ptr] <= PWDATA;
   end
`else
   logic unused_busy;
   assign unused_busy = i_BUSY;
   assign push  = access & wr_fifo;
   assign pop   = 1'b0;
   assign level = 3'd0;
   assign head  = 8'h00;
`endif

endmodule

// File: tb/tb_apb_spi_bridge.sv
module tb_apb_spi_bridge;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [3:0] PADDR = 4'h0;
   logic [7:0] PWDATA = 8'h00;
   logic [7:0] PRDATA;
   logic       PREADY, PSLVERR;
   logic       o_WR0, o_WR1, o_WR2, o_WR3;
   logic       o_DR0, o_DR1, o_DR2, o_DR3;
   logic [7:0] o_PWDATA;
   logic [7:0] i_PRDATA = 8'h00;
   logic       i_BUSY = 1'b0;

   apb_spi_bridge dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR),
      .o_WR0(o_WR0), .o_WR1(o_WR1), .o_WR2(o_WR2), .o_WR3(o_WR3),
      .o_DR0(o_DR0), .o_DR1(o_DR1), .o_DR2(o_DR2), .o_DR3(o_DR3),
      .o_PWDATA(o_PWDATA), .i_PRDATA(i_PRDATA), .i_BUSY(i_BUSY)
   );

   always #5 PCLK = ~PCLK;

   logic [7:0] strb;
   assign strb = {o_DR3, o_DR2, o_DR1, o_DR0, o_WR3, o_WR2, o_WR1, o_WR0};

   int checks = 0;
   int errors = 0;
   int multi  = 0;

   always @(negedge PCLK) if ($countones(strb) > 1) multi++;

   typedef struct {
      bit         wr;
      logic [3:0] addr;
      logic [7:0] wd;
      logic [7:0] rsp;
      int         waits;
      bit         err;
      logic [7:0] strb;
      bit         chk_rd;
      logic [7:0] prd;
   } vec_t;

   vec_t vt [15];

   int         r_waits;
   logic [7:0] r_fs, r_fp, r_ls, r_lp, r_prd;
   bit         r_err, r_to;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // One APB transfer. The SPI read response is presented in the cycle after
   // the read strobe, as the SPI master would.
   task automatic apb(input bit wr, input logic [3:0] addr, input logic [7:0] wd,
                      input logic [7:0] rsp);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      r_waits = 0; r_to = 1'b0; r_ls = 8'h00; r_lp = 8'h00;
      @(negedge PCLK);
      r_fs = strb; r_fp = o_PWDATA;
      while (!PREADY) begin
         if (r_waits >= 64) begin r_to = 1'b1; break; end
         @(posedge PCLK); #1;
         r_waits++;
         if (r_waits == 1 && r_fs[7:4] != 4'h0) i_PRDATA = rsp;
         @(negedge PCLK);
         r_ls = strb; r_lp = o_PWDATA;
      end
      r_prd = PRDATA; r_err = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; i_PRDATA = 8'h00;
   endtask

   task automatic do_reset();
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; i_PRDATA = 8'h00;
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      @(posedge PCLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int got;
      int nstrb;
      logic [7:0] gd;

      vt[0]  = '{1'b1, 4'h3, 8'hA5, 8'h00, 0, 1'b0, 8'h08, 1'b0, 8'h00};
      vt[1]  = '{1'b1, 4'h0, 8'h5A, 8'h00, 0, 1'b0, 8'h01, 1'b0, 8'h00};
      vt[2]  = '{1'b1, 4'h2, 8'hC3, 8'h00, 0, 1'b0, 8'h04, 1'b0, 8'h00};
      vt[3]  = '{1'b0, 4'h4, 8'h00, 8'h81, 1, 1'b0, 8'h10, 1'b1, 8'h81};
      vt[4]  = '{1'b0, 4'h5, 8'h00, 8'h3C, 1, 1'b0, 8'h20, 1'b1, 8'h3C};
      vt[5]  = '{1'b0, 4'h6, 8'h00, 8'h5E, 1, 1'b0, 8'h40, 1'b1, 8'h5E};
      vt[6]  = '{1'b0, 4'h7, 8'h00, 8'hF0, 1, 1'b0, 8'h80, 1'b1, 8'hF0};
      vt[7]  = '{1'b0, 4'h0, 8'h00, 8'h00, 0, 1'b1, 8'h00, 1'b0, 8'h00};
      vt[8]  = '{1'b0, 4'h3, 8'h00, 8'h00, 0, 1'b1, 8'h00, 1'b0, 8'h00};
      vt[9]  = '{1'b1, 4'h5, 8'h12, 8'h00, 0, 1'b1, 8'h00, 1'b0, 8'h00};
      vt[10] = '{1'b1, 4'h8, 8'h34, 8'h00, 0, 1'b1, 8'h00, 1'b0, 8'h00};
      vt[11] = '{1'b0, 4'hC, 8'h00, 8'h00, 0, 1'b1, 8'h00, 1'b0, 8'h00};
      vt[12] = '{1'b1, 4'hC, 8'h56, 8'h00, 0, 1'b1, 8'h00, 1'b0, 8'h00};
`ifdef APB_SPI_BRIDGE_TXFIFO_EN
      vt[13] = '{1'b1, 4'h1, 8'h66, 8'h00, 0, 1'b0, 8'h00, 1'b0, 8'h00};
      vt[14] = '{1'b0, 4'h8, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b1, 8'h01};
`else
      vt[13] = '{1'b1, 4'h1, 8'h66, 8'h00, 0, 1'b0, 8'h02, 1'b0, 8'h00};
      vt[14] = '{1'b0, 4'h8, 8'h00, 8'h00, 0, 1'b1, 8'h00, 1'b0, 8'h00};
`endif

      // Reset state, sampled while reset is held.
      repeat (2) @(negedge PCLK);
      chk("rst_pready",  PREADY,   0);
      chk("rst_pslverr", PSLVERR,  0);
      chk("rst_strobes", strb,     0);
      chk("rst_pwdata",  o_PWDATA, 0);
      chk("rst_prdata",  PRDATA,   0);
      @(posedge PCLK); #1 PRESETn = 1'b1;
      @(posedge PCLK); #1;

      // Busy held so nothing queued at 0x1 drains during the table.
      i_BUSY = 1'b1;
      for (int i = 0; i < 15; i++) begin
         apb(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].rsp);
         chk($sformatf("v%0d_timeout", i), r_to, 0);
         chk($sformatf("v%0d_waits", i), r_waits, vt[i].waits);
         chk($sformatf("v%0d_pslverr", i), r_err, vt[i].err);
         chk($sformatf("v%0d_strobe", i), r_fs, vt[i].strb);
         if (vt[i].wr && vt[i].strb != 8'h00)
            chk($sformatf("v%0d_pwdata", i), r_fp, vt[i].wd);
         if (r_waits > 0)
            chk($sformatf("v%0d_late_strobe", i), r_ls, 0);
         if (vt[i].chk_rd)
            chk($sformatf("v%0d_prdata", i), r_prd, vt[i].prd);
         @(negedge PCLK);
         chk($sformatf("v%0d_idle_strobe", i), strb, 0);
      end

`ifdef APB_SPI_BRIDGE_TXFIFO_EN
      // Fill the FIFO with the SPI master busy, then stall on the fifth push.
      do_reset();
      i_BUSY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apb(1'b1, 4'h1, 8'h11 + 8'(i), 8'h00);
         chk($sformatf("fill%0d_waits", i), r_waits, 0);
         chk($sformatf("fill%0d_strobe", i), r_fs, 0);
      end
      apb(1'b0, 4'h8, 8'h00, 8'h00);
      chk("full_level", r_prd, 4);
      chk("full_level_err", r_err, 0);
      fork
         apb(1'b1, 4'h1, 8'h15, 8'h00);
         begin repeat (5) @(posedge PCLK); #1 i_BUSY = 1'b0; end
      join
      chk("stall_timeout", r_to, 0);
      chk("stall_first_strobe", r_fs, 0);
      chk("stall_waits", r_waits, 3);
      chk("stall_pop_strobe", r_ls, 8'h02);
      chk("stall_pop_data", r_lp, 8'h11);

      // i_BUSY never rises: next hand-over only after the 16-cycle timeout.
      got = 0; gd = 8'h00;
      for (int k = 1; k <= 40; k++) begin
         @(negedge PCLK);
         if (o_WR1) begin got = k; gd = o_PWDATA; break; end
      end
      chk("timeout_gap", got, 17);
      chk("timeout_data", gd, 8'h12);

      // CPU write to 0x0 in the cycle the drain becomes eligible.
      do_reset();
      i_BUSY = 1'b1;
      apb(1'b1, 4'h1, 8'h77, 8'h00);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 8'h99;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; i_BUSY = 1'b0;
      @(negedge PCLK);
      chk("prio_cpu_strobe", strb, 8'h01);
      chk("prio_cpu_data", o_PWDATA, 8'h99);
      chk("prio_cpu_pready", PREADY, 1);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      chk("prio_drain_strobe", strb, 8'h02);
      chk("prio_drain_data", o_PWDATA, 8'h77);
`endif

      // Reset with two bytes queued and a read in its first access cycle.
      do_reset();
      i_BUSY = 1'b1;
      apb(1'b1, 4'h1, 8'h21, 8'h00);
      apb(1'b1, 4'h1, 8'h22, 8'h00);
      chk("q2_err", r_err, 0);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h5;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      chk("midrst_dr1", strb, 8'h20);
      @(posedge PCLK); #1;
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      chk("midrst_strobes", strb, 0);
      chk("midrst_pready", PREADY, 0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1; i_BUSY = 1'b0;
      nstrb = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge PCLK);
         if (strb != 8'h00) nstrb++;
      end
      chk("postrst_no_strobe", nstrb, 0);
      apb(1'b0, 4'h8, 8'h00, 8'h00);
      chk("postrst_timeout", r_to, 0);
`ifdef APB_SPI_BRIDGE_TXFIFO_EN
      chk("postrst_level", r_prd, 0);
      chk("postrst_level_err", r_err, 0);
`else
      chk("postrst_stat_err", r_err, 1);
`endif

      chk("strobe_exclusive", multi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_spi_bridge.md
APB_SPI_BRIDGE -- requirements
Module: apb_spi_bridge

Interface
REQ-001 SHALL have PCLK, input, 1: the single clock; all logic is rising-edge.
REQ-002 SHALL have PRESETn, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have PSEL, PENABLE, PWRITE, inputs, 1 each: APB3 control.
REQ-004 SHALL have PADDR, input, 4: register address.
REQ-005 SHALL have PWDATA, input, 8: APB write data.
REQ-006 SHALL have PRDATA, output, 8: registered read data.
REQ-007 SHALL have PREADY and PSLVERR, outputs, 1 each: transfer completion and error.
REQ-008 SHALL have o_WR0..o_WR3, outputs, 1 each: one-cycle write strobes to the SPI master (CONFIG, TX, RX, CMD).
REQ-009 SHALL have o_DR0..o_DR3, outputs, 1 each: one-cycle read strobes to the SPI master (STATE, RX, OPT2, OPT3).
REQ-010 SHALL have o_PWDATA, output, 8: data that accompanies any o_WRn strobe.
REQ-011 SHALL have i_PRDATA, input, 8: SPI master read data, valid in the cycle after an o_DRn strobe.
REQ-012 SHALL have i_BUSY, input, 1: SPI master transfer in progress.

Function
REQ-013 SHALL decode addresses as: 0x0-0x3 write to WR0-WR3; 0x4-0x7 read from DR0-DR3; 0x8 read-only FIFO status {5'b0, level[2:0]}.
REQ-014 SHALL treat any other address, a write to 0x4-0x8, or a read from 0x0-0x3 as an error: PREADY=1 and PSLVERR=1 in the first access cycle, with no strobe.
REQ-015 SHALL complete a write to 0x0, 0x2 or 0x3 in the first access cycle (PREADY=1), and assert o_WRn together with o_PWDATA=PWDATA in that same cycle.
REQ-016 SHALL, for a write to 0x1, push PWDATA into a 4-deep TX FIFO and complete with PREADY=1 in the first access cycle when the FIFO is not full.
REQ-017 SHALL hold PREADY=0 while the FIFO is full, and SHALL complete the push in the cycle a slot frees; a push and a pop in the same cycle are both legal.
REQ-018 SHALL, for a read from 0x4-0x7, pulse o_DRn in the first access cycle with PREADY=0, then latch i_PRDATA into PRDATA with PREADY=1 in the next cycle, giving one wait state.
REQ-019 SHALL complete a read from 0x8 in the first access cycle with the current FIFO level.
REQ-020 SHALL implement the drain FSM with the states D_IDLE, D_WAITHI and D_WAITLO.
REQ-021 SHALL, in D_IDLE, when the FIFO is not empty, i_BUSY=0 and no CPU o_WRn or o_DRn strobe occurs this cycle, pulse o_WR1 with the FIFO head on o_PWDATA, pop the FIFO, and go to D_WAITHI.
REQ-022 SHALL give a CPU strobe priority over the drain in the same cycle; the drain retries on the next cycle.
REQ-023 SHALL move from D_WAITHI to D_WAITLO when i_BUSY=1, or back to D_IDLE after 16 cycles without i_BUSY (timeout; the byte is considered sent).
REQ-024 SHALL move from D_WAITLO to D_IDLE when i_BUSY=0.
REQ-025 SHALL assert at most one of o_WR0..3 and o_DR0..3 in any cycle.
REQ-026 SHALL keep the FIFO pointers 2 bits wide with natural wrap-around, and the level counter 3 bits wide (0-4).

Reset
REQ-027 SHALL, while PRESETn=0, asynchronously clear: PRDATA=0, PREADY=0, PSLVERR=0, all strobes=0, o_PWDATA=0, FIFO empty, drain FSM=D_IDLE, timeout counter=0.
REQ-028 SHALL discard an APB transfer or drain in progress when reset is asserted mid-operation, with no strobe issued after release until a new request arrives.

Configuration
REQ-029 SHALL compile the TX FIFO and drain FSM only when APB_SPI_BRIDGE_TXFIFO_EN is defined.
REQ-030 SHALL, without APB_SPI_BRIDGE_TXFIFO_EN, treat a write to 0x1 like 0x0/0x2/0x3 (immediate o_WR1, no wait state) and treat address 0x8 as an error (PSLVERR=1).

Verification
REQ-031 SHALL test: APB write 0x3=0xA5 -> o_WR3 one cycle with o_PWDATA=0xA5, PREADY=1 in the first access cycle, PSLVERR=0.
REQ-032 SHALL test: APB read 0x5 with i_PRDATA=0x3C the cycle after o_DR1 -> one wait state, then PRDATA=0x3C with PREADY=1.
REQ-033 SHALL test: five writes to 0x1 (0x11-0x15) with i_BUSY held 1 -> 0x8 reads 4, and the fifth write stalls with PREADY=0 until i_BUSY drops and the first o_WR1 (0x11) pops.
REQ-034 SHALL test: i_BUSY never rises after a drain o_WR1 -> the next o_WR1 is issued only after the 16-cycle timeout.
REQ-035 SHALL test: CPU write 0x0 in the same cycle the drain is eligible -> o_WR0 first, o_WR1 the next cycle, never both together.
REQ-036 SHALL test: access to 0xC, and PRESETn pulsed low with 2 bytes queued -> PSLVERR=1 with no strobe; after reset 0x8 reads 0 and no o_WR1 is issued.
